// File: rtl/dsa_bilinear_seq_core_if.sv
// dsa_bilinear_seq_core_if: bridge/BRAM-side signal bundle for the bilinear scaler.
//   slave  modport : the scaler core
//   master modport : the environment (vJTAG bridge registers, input and output BRAMs)
interface dsa_bilinear_seq_core_if #(
    parameter int AW = 12
);
    logic          start_pulse;
    logic [15:0]   cfg_in_w;
    logic [15:0]   cfg_in_h;
    logic [15:0]   cfg_scale_q88;
    logic [AW-1:0] in_mem_raddr;
    logic [7:0]    in_mem_rdata;
    logic [AW-1:0] out_mem_waddr;
    logic [7:0]    out_mem_wdata;
    logic          out_mem_we;
    logic          status_done;
    logic          status_busy;
    logic [15:0]   out_w;
    logic [15:0]   out_h;

    modport slave (
        input  start_pulse,
        input  cfg_in_w,
        input  cfg_in_h,
        input  cfg_scale_q88,
        output in_mem_raddr,
        input  in_mem_rdata,
        output out_mem_waddr,
        output out_mem_wdata,
        output out_mem_we,
        output status_done,
        output status_busy,
        output out_w,
        output out_h
    );

    modport master (
        output start_pulse,
        output cfg_in_w,
        output cfg_in_h,
        output cfg_scale_q88,
        input  in_mem_raddr,
        output in_mem_rdata,
        input  out_mem_waddr,
        input  out_mem_wdata,
        input  out_mem_we,
        input  status_done,
        input  status_busy,
        input  out_w,
        input  out_h
    );
endinterface

// File: rtl/dsa_bilinear_seq_core.sv
// dsa_bilinear_seq_core: sequential bilinear scaler, 8-bit grayscale, BRAM in / BRAM out.
// One run: latch cfg on start edge, 16-cycle reciprocal divide, then 7 cycles per output
// pixel in raster order, then a one-cycle DONE that raises status_done.
// Build option: define DSA_BILINEAR_ROUND_EN to round pixels half-up; otherwise they truncate.
module dsa_bilinear_seq_core #(
    parameter int AW = 12
) (
    input  logic                   clk_sys,
    input  logic                   rst_sys_n,
    dsa_bilinear_seq_core_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DIV   = 3'd1,
        ST_SETUP = 3'd2,
        ST_PIX   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] LP_PH_LAST = 3'd6;
    localparam logic [3:0] LP_DIV_LAST = 4'd15;

    // Saturate a shifted 32-bit dimension product to 16 bits.
    function automatic logic [15:0] sat16(input logic [31:0] v);
        logic [15:0] r;
        if (v > 32'h0000_FFFF) begin
            r = 16'hFFFF;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    // Integer part of a Q.8 source coordinate, clamped to the last valid index.
    function automatic logic [15:0] clamp_lo(input logic [23:0] ipart, input logic [15:0] lim);
        logic [15:0] r;
        if (ipart > {8'd0, lim}) begin
            r = lim;
        end else begin
            r = ipart[15:0];
        end
        return r;
    endfunction

    // Right-hand / lower neighbour index, clamped to the last valid index.
    function automatic logic [15:0] clamp_hi(input logic [15:0] c0, input logic [15:0] lim);
        logic [15:0] r;
        if (c0 < lim) begin
            r = c0 + 16'd1;
        end else begin
            r = lim;
        end
        return r;
    endfunction

    // Saturate the scaled accumulator to an 8-bit pixel.
    function automatic logic [7:0] sat8(input logic [9:0] v);
        logic [7:0] r;
        if (v > 10'd255) begin
            r = 8'd255;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_start_d;
    logic [15:0]   r_in_w;
    logic [15:0]   r_in_h;
    logic [15:0]   r_scale;
    logic [15:0]   r_out_w;
    logic [15:0]   r_out_h;
    logic          r_done;
    logic          r_busy;
    logic [15:0]   r_div_rem;
    logic [15:0]   r_inv;
    logic [3:0]    r_div_cnt;
    logic [2:0]    r_phase;
    logic [15:0]   r_ox;
    logic [15:0]   r_oy;
    logic [31:0]   r_src_x;
    logic [31:0]   r_src_y;
    logic [7:0]    r_p00;
    logic [7:0]    r_p01;
    logic [7:0]    r_p10;
    logic [7:0]    r_p11;
    logic [AW:0]   r_wcnt;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [7:0]    r_wdata;

    logic          w_start;
    logic [31:0]   w_prod_w;
    logic [31:0]   w_prod_h;
    logic [15:0]   w_ow_calc;
    logic [15:0]   w_oh_calc;
    logic          w_degen;
    logic [16:0]   w_div_t;
    logic          w_div_ge;
    logic [15:0]   w_div_sub;
    logic [15:0]   w_in_w_m1;
    logic [15:0]   w_in_h_m1;
    logic [15:0]   w_x0;
    logic [15:0]   w_x1;
    logic [15:0]   w_y0;
    logic [15:0]   w_y1;
    logic [8:0]    w_fx;
    logic [8:0]    w_fx_n;
    logic [8:0]    w_fy;
    logic [8:0]    w_fy_n;
    logic [16:0]   w_h0;
    logic [16:0]   w_h1;
    logic [25:0]   w_acc;
    logic [25:0]   w_acc_adj;
    logic [9:0]    w_pix_wide;
    logic [7:0]    w_pix;
    logic [15:0]   w_rd_x;
    logic [15:0]   w_rd_y;
    logic [AW-1:0] w_raddr;
    logic          w_last_col;
    logic          w_last_row;

    // ---------------- combinational datapath ----------------
    assign w_start   = bus.start_pulse & ~r_start_d;

    // Output dimensions come straight from the live cfg so they can be latched on the start edge
    assign w_prod_w  = bus.cfg_in_w * bus.cfg_scale_q88;
    assign w_prod_h  = bus.cfg_in_h * bus.cfg_scale_q88;
    assign w_ow_calc = sat16(w_prod_w >> 8);
    assign w_oh_calc = sat16(w_prod_h >> 8);
    assign w_degen   = (bus.cfg_scale_q88 == 16'd0) || (bus.cfg_in_w == 16'd0) ||
                       (bus.cfg_in_h == 16'd0) || (w_ow_calc == 16'd0) || (w_oh_calc == 16'd0);

    // Restoring divide of 65536 by scale; the leading dividend bit is preloaded into the
    // remainder, so scale==1 naturally yields all-ones (the saturated 0xFFFF)
    assign w_div_t   = {r_div_rem, 1'b0};
    assign w_div_ge  = (w_div_t >= {1'b0, r_scale});
    assign w_div_sub = w_div_t[15:0] - r_scale;

    assign w_in_w_m1 = r_in_w - 16'd1;
    assign w_in_h_m1 = r_in_h - 16'd1;
    assign w_x0      = clamp_lo(r_src_x[31:8], w_in_w_m1);
    assign w_y0      = clamp_lo(r_src_y[31:8], w_in_h_m1);
    assign w_x1      = clamp_hi(w_x0, w_in_w_m1);
    assign w_y1      = clamp_hi(w_y0, w_in_h_m1);
    assign w_fx      = {1'b0, r_src_x[7:0]};
    assign w_fy      = {1'b0, r_src_y[7:0]};
    assign w_fx_n    = 9'd256 - w_fx;
    assign w_fy_n    = 9'd256 - w_fy;

    // Horizontal blends then vertical blend; all weights sum to 256 per axis
    assign w_h0      = 17'(r_p00) * 17'(w_fx_n) + 17'(r_p01) * 17'(w_fx);
    assign w_h1      = 17'(r_p10) * 17'(w_fx_n) + 17'(r_p11) * 17'(w_fx);
    assign w_acc     = 26'(w_h0) * 26'(w_fy_n) + 26'(w_h1) * 26'(w_fy);

`ifdef DSA_BILINEAR_ROUND_EN
    assign w_acc_adj = w_acc + 26'd32768;
`else
    assign w_acc_adj = w_acc;
`endif

    assign w_pix_wide = 10'(w_acc_adj >> 16);
    assign w_pix      = sat8(w_pix_wide);

    assign w_last_col = (r_ox == (r_out_w - 16'd1));
    assign w_last_row = (r_oy == (r_out_h - 16'd1));

    // Pick the neighbour whose read is issued in the current pixel phase
    always_comb begin
        w_rd_x = 16'd0;
        w_rd_y = 16'd0;
        if (r_state == ST_PIX) begin
            case (r_phase)
                3'd0: begin w_rd_x = w_x0; w_rd_y = w_y0; end
                3'd1: begin w_rd_x = w_x1; w_rd_y = w_y0; end
                3'd2: begin w_rd_x = w_x0; w_rd_y = w_y1; end
                3'd3: begin w_rd_x = w_x1; w_rd_y = w_y1; end
                default: begin w_rd_x = 16'd0; w_rd_y = 16'd0; end
            endcase
        end else begin
            w_rd_x = 16'd0;
            w_rd_y = 16'd0;
        end
    end

    // The BRAM samples the address at the end of the issuing phase, so it is driven directly
    assign w_raddr = AW'(w_rd_y * r_in_w + w_rd_x);

    // ---------------- FSM ----------------
    // State register
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (w_degen) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_DIV;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (r_div_cnt == LP_DIV_LAST) begin
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_state_nxt = ST_DIV;
                end
            end
            ST_SETUP: w_state_nxt = ST_PIX;
            ST_PIX: begin
                if ((r_phase == LP_PH_LAST) && w_last_col && w_last_row) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_PIX;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Run datapath: cfg latch, divider, coordinate accumulators, pixel pipeline, status
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_start_d <= 1'b0;
            r_in_w    <= 16'd0;
            r_in_h    <= 16'd0;
            r_scale   <= 16'd0;
            r_out_w   <= 16'd0;
            r_out_h   <= 16'd0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_div_rem <= 16'd0;
            r_inv     <= 16'd0;
            r_div_cnt <= 4'd0;
            r_phase   <= 3'd0;
            r_ox      <= 16'd0;
            r_oy      <= 16'd0;
            r_src_x   <= 32'd0;
            r_src_y   <= 32'd0;
            r_p00     <= 8'd0;
            r_p01     <= 8'd0;
            r_p10     <= 8'd0;
            r_p11     <= 8'd0;
            r_wcnt    <= {(AW+1){1'b0}};
            r_we      <= 1'b0;
            r_waddr   <= {AW{1'b0}};
            r_wdata   <= 8'd0;
        end else begin
            r_start_d <= bus.start_pulse;
            r_we      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_in_w    <= bus.cfg_in_w;
                        r_in_h    <= bus.cfg_in_h;
                        r_scale   <= bus.cfg_scale_q88;
                        r_out_w   <= w_ow_calc;
                        r_out_h   <= w_oh_calc;
                        r_done    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_div_rem <= 16'd1;
                        r_inv     <= 16'd0;
                        r_div_cnt <= 4'd0;
                    end
                end
                ST_DIV: begin
                    r_div_cnt <= r_div_cnt + 4'd1;
                    if (w_div_ge) begin
                        r_div_rem <= w_div_sub;
                    end else begin
                        r_div_rem <= w_div_t[15:0];
                    end
                    r_inv <= {r_inv[14:0], w_div_ge};
                end
                ST_SETUP: begin
                    r_ox    <= 16'd0;
                    r_oy    <= 16'd0;
                    r_src_x <= 32'd0;
                    r_src_y <= 32'd0;
                    r_wcnt  <= {(AW+1){1'b0}};
                    r_phase <= 3'd0;
                end
                ST_PIX: begin
                    if (r_phase == LP_PH_LAST) begin
                        r_phase <= 3'd0;
                    end else begin
                        r_phase <= r_phase + 3'd1;
                    end
                    case (r_phase)
                        3'd1: r_p00 <= bus.in_mem_rdata;
                        3'd2: r_p01 <= bus.in_mem_rdata;
                        3'd3: r_p10 <= bus.in_mem_rdata;
                        3'd4: r_p11 <= bus.in_mem_rdata;
                        3'd5: begin
                            // Stage the write so the strobe is a clean registered P6 pulse;
                            // pixels past the end of the output BRAM are dropped
                            r_we    <= ~r_wcnt[AW];
                            r_waddr <= r_wcnt[AW-1:0];
                            r_wdata <= w_pix;
                        end
                        3'd6: begin
                            if (!r_wcnt[AW]) begin
                                r_wcnt <= r_wcnt + {{AW{1'b0}}, 1'b1};
                            end
                            if (w_last_col) begin
                                r_ox    <= 16'd0;
                                r_src_x <= 32'd0;
                                r_oy    <= r_oy + 16'd1;
                                r_src_y <= r_src_y + {16'd0, r_inv};
                            end else begin
                                r_ox    <= r_ox + 16'd1;
                                r_src_x <= r_src_x + {16'd0, r_inv};
                            end
                        end
                        default: begin
                            r_p00 <= r_p00;
                        end
                    endcase
                end
                ST_DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_mem_raddr  = w_raddr;
    assign bus.out_mem_waddr = r_waddr;
    assign bus.out_mem_wdata = r_wdata;
    assign bus.out_mem_we    = r_we;
    assign bus.status_done   = r_done;
    assign bus.status_busy   = r_busy;
    assign bus.out_w         = r_out_w;
    assign bus.out_h         = r_out_h;

endmodule

// File: tb/tb_dsa_bilinear_seq_core.sv
// tb_dsa_bilinear_seq_core: directed and randomized runs of the bilinear scaler,
// checked against a direct-arithmetic reference model of the scaling rules.
module tb_dsa_bilinear_seq_core;
    localparam int AW    = 12;
    localparam int MEM_N = 1 << AW;

    logic clk_sys   = 1'b0;
    logic rst_sys_n = 1'b0;
    int   n_checks  = 0;
    int   n_errors  = 0;

    logic [7:0] in_mem  [0:MEM_N-1];
    logic [7:0] out_mem [0:MEM_N-1];
    int         wr_addr_q[$];
    int         wr_data_q[$];

    dsa_bilinear_seq_core_if #(.AW(AW)) bus();

    dsa_bilinear_seq_core #(.AW(AW)) dut (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .bus       (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // input BRAM: synchronous read, one-cycle latency
    always @(posedge clk_sys) bus.in_mem_rdata <= in_mem[bus.in_mem_raddr];

    // output BRAM plus an ordered log of every write strobe
    always @(posedge clk_sys) begin
        if (bus.out_mem_we === 1'b1) begin
            out_mem[bus.out_mem_waddr] <= bus.out_mem_wdata;
            wr_addr_q.push_back(int'(bus.out_mem_waddr));
            wr_data_q.push_back(int'(bus.out_mem_wdata));
        end
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: pixel value from the bilinear rules using direct multiplication
    function automatic int ref_pix(int ox, int oy, int inw, int inh, int inv);
        longint sx, sy, acc;
        int x0, x1, y0, y1, fx, fy, p00, p01, p10, p11, pix;
        sx = longint'(ox) * inv;
        sy = longint'(oy) * inv;
        x0 = (sx / 256 > inw - 1) ? inw - 1 : int'(sx / 256);
        y0 = (sy / 256 > inh - 1) ? inh - 1 : int'(sy / 256);
        fx = int'(sx % 256);
        fy = int'(sy % 256);
        x1 = (x0 + 1 > inw - 1) ? inw - 1 : x0 + 1;
        y1 = (y0 + 1 > inh - 1) ? inh - 1 : y0 + 1;
        p00 = int'(in_mem[int'((longint'(y0) * inw + x0) % MEM_N)]);
        p01 = int'(in_mem[int'((longint'(y0) * inw + x1) % MEM_N)]);
        p10 = int'(in_mem[int'((longint'(y1) * inw + x0) % MEM_N)]);
        p11 = int'(in_mem[int'((longint'(y1) * inw + x1) % MEM_N)]);
        acc = longint'(p00 * (256 - fx) + p01 * fx) * (256 - fy)
            + longint'(p10 * (256 - fx) + p11 * fx) * fy;
`ifdef DSA_BILINEAR_ROUND_EN
        pix = int'((acc + 32768) / 65536);
`else
        pix = int'(acc / 65536);
`endif
        if (pix > 255) pix = 255;
        return pix;
    endfunction

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_done"},  bus.status_done,   0);
        check_eq({tag, "_busy"},  bus.status_busy,   0);
        check_eq({tag, "_we"},    bus.out_mem_we,    0);
        check_eq({tag, "_waddr"}, bus.out_mem_waddr, 0);
        check_eq({tag, "_wdata"}, bus.out_mem_wdata, 0);
        check_eq({tag, "_raddr"}, bus.in_mem_raddr,  0);
        check_eq({tag, "_out_w"}, bus.out_w,         0);
        check_eq({tag, "_out_h"}, bus.out_h,         0);
    endtask

    // One complete run; restart_at>0 raises start_pulse again at that cycle of the run
    task automatic run_case(input string tag, input int inw, input int inh, input int scale,
                            input int restart_at);
        longint ow, oh;
        int     inv, npix, nexp, budget, cycles, done_at, nwr;
        bit     busy_bad;
        ow = (longint'(inw) * scale) / 256;
        oh = (longint'(inh) * scale) / 256;
        if (ow > 65535) ow = 65535;
        if (oh > 65535) oh = 65535;
        inv = (scale == 0) ? 0 : 65536 / scale;
        if (inv > 65535) inv = 65535;
        npix = (ow == 0 || oh == 0) ? 0 : int'(ow * oh);
        nexp = (npix > MEM_N) ? MEM_N : npix;
        budget = 18 + 7 * npix + 60;
        wr_addr_q.delete();
        wr_data_q.delete();
        bus.cfg_in_w      = 16'(inw);
        bus.cfg_in_h      = 16'(inh);
        bus.cfg_scale_q88 = 16'(scale);
        @(negedge clk_sys);
        bus.start_pulse = 1'b1;
        @(posedge clk_sys);
        #1;
        check_eq({tag, "_busy_on"},  bus.status_busy, 1);
        check_eq({tag, "_done_clr"}, bus.status_done, 0);
        cycles   = 0;
        done_at  = -1;
        busy_bad = 1'b0;
        while (cycles < budget) begin
            @(posedge clk_sys);
            #1;
            cycles++;
            if (cycles == 7) bus.start_pulse = 1'b0;
            if (restart_at > 0 && cycles == restart_at) bus.start_pulse = 1'b1;
            if (restart_at > 0 && cycles == restart_at + 8) bus.start_pulse = 1'b0;
            if (done_at < 0) begin
                if (bus.status_done) done_at = cycles;
                else if (!bus.status_busy) busy_bad = 1'b1;
            end
            if (done_at >= 0 && cycles >= 7 && (restart_at == 0 || cycles >= restart_at + 8))
                break;
        end
        check_eq({tag, "_done_cyc"}, done_at, (npix == 0) ? 1 : 18 + 7 * npix);
        check_eq({tag, "_busy_run"}, busy_bad, 0);
        repeat (2) @(posedge clk_sys);
        #1;
        check_eq({tag, "_done_hold"}, bus.status_done, 1);
        check_eq({tag, "_busy_off"},  bus.status_busy, 0);
        check_eq({tag, "_out_w"},     bus.out_w, ow);
        check_eq({tag, "_out_h"},     bus.out_h, oh);
        nwr = wr_addr_q.size();
        check_eq({tag, "_n_wr"}, nwr, nexp);
        for (int i = 0; i < nexp && i < nwr; i++) begin
            check_eq({tag, "_waddr"}, wr_addr_q[i], i);
            check_eq({tag, "_pix"}, wr_data_q[i],
                     ref_pix(i % int'(ow), i / int'(ow), inw, inh, inv));
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < MEM_N; i++) in_mem[i] = 8'd0;
        for (int i = 0; i < 16; i++) in_mem[i] = 8'(i * 10);
    endtask

    initial begin
        int inw, inh, scale;
        bus.start_pulse   = 1'b0;
        bus.cfg_in_w      = 16'd0;
        bus.cfg_in_h      = 16'd0;
        bus.cfg_scale_q88 = 16'd0;
        for (int i = 0; i < MEM_N; i++) begin
            in_mem[i]  = 8'd0;
            out_mem[i] = 8'd0;
        end
        rst_sys_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        check_idle_zero("por");
        @(negedge clk_sys);
        rst_sys_n = 1'b1;

        // identity scale on a 4x4 ramp
        load_ramp();
        run_case("ramp_x1", 4, 4, 256, 0);
        for (int i = 0; i < 16; i++) check_eq("ramp_x1_out", out_mem[i], i * 10);

        // half scale picks every second source pixel
        run_case("ramp_half", 4, 4, 128, 0);
        check_eq("half_out0", out_mem[0], 0);
        check_eq("half_out1", out_mem[1], 20);
        check_eq("half_out2", out_mem[2], 80);

        // 2x upscale of a 2x2 image, including the right/bottom clamps
        in_mem[0] = 8'd0;
        in_mem[1] = 8'd100;
        in_mem[2] = 8'd200;
        in_mem[3] = 8'd255;
        run_case("up2x", 2, 2, 512, 0);
        check_eq("up2x_out1",  out_mem[1],  50);
        check_eq("up2x_out3",  out_mem[3],  100);
        check_eq("up2x_out12", out_mem[12], 200);
`ifdef DSA_BILINEAR_ROUND_EN
        check_eq("up2x_out5", out_mem[5], 139);
`else
        check_eq("up2x_out5", out_mem[5], 138);
`endif

        // degenerate runs: no writes, done right away; saturated dimension reporting
        run_case("scale0", 4, 4, 0, 0);
        run_case("inw0", 0, 4, 256, 0);
        run_case("dim_sat", 65535, 0, 65535, 0);

        // a second start edge during a busy run must not restart it
        load_ramp();
        run_case("restart", 4, 4, 256, 20);

        // reset in the middle of a run
        bus.cfg_in_w      = 16'd4;
        bus.cfg_in_h      = 16'd4;
        bus.cfg_scale_q88 = 16'd256;
        @(negedge clk_sys);
        bus.start_pulse = 1'b1;
        repeat (8) @(posedge clk_sys);
        #1;
        bus.start_pulse = 1'b0;
        repeat (30) @(posedge clk_sys);
        #1;
        check_eq("midrun_busy", bus.status_busy, 1);
        rst_sys_n = 1'b0;
        #1;
        check_idle_zero("midrun_rst");
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
        for (int i = 0; i < 16; i++) out_mem[i] = 8'd0;
        run_case("after_rst", 4, 4, 256, 0);
        for (int i = 0; i < 16; i++) check_eq("after_rst_out", out_mem[i], i * 10);

        // randomized sizes, scales and images
        for (int r = 0; r < 12; r++) begin
            inw   = int'($urandom_range(1, 10));
            inh   = int'($urandom_range(1, 10));
            scale = int'($urandom_range(64, 640));
            for (int i = 0; i < MEM_N; i++) in_mem[i] = 8'($urandom_range(0, 255));
            run_case("rnd", inw, inh, scale, 0);
        end

        // more output pixels than the output BRAM holds: tail writes are dropped
        for (int i = 0; i < MEM_N; i++) in_mem[i] = 8'($urandom_range(0, 255));
        run_case("wr_ovf", 65, 64, 256, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
